pc_unit_ras: RTL

Parametrised program-counter unit for the sequential-logic datapath: the next generation of our basic clear/hold/increment/jump PC. It adds a configurable step, a reset vector, PC-relative branches, and call/return through a hardware return-address stack (RAS) with full/empty/error status. It sits between the control FSM, which drives the op and target, and instruction fetch, which consumes `pc_o`.

---
 rtl/pc_unit_ras.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pc_unit_ras.sv
// Program-counter unit: clear/hold/increment/jump/branch plus call/return.
// Define PC_RAS_EN to build the circular return-address stack; otherwise RET returns to link_o.
module pc_unit_ras #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       STEP         = 4,
    parameter int unsigned       RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               en,
    input  logic [2:0]                         op_i,
    input  logic [WIDTH-1:0]                   target_i,
    output logic [WIDTH-1:0]                   pc_o,
    output logic [WIDTH-1:0]                   link_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count_o,
    output logic                               ras_full_o,
    output logic                               ras_empty_o,
    output logic                               ras_err_o
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [2:0] {
        OP_CLEAR  = 3'b000,
        OP_HOLD   = 3'b001,
        OP_INC    = 3'b010,
        OP_JUMP   = 3'b011,
        OP_BRANCH = 3'b100,
        OP_CALL   = 3'b101,
        OP_RET    = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] base,
                                                  input logic signed [WIDTH-1:0] delta);
        return base + $unsigned(delta);
    endfunction

    op_e                      op;
    logic [WIDTH-1:0]         pc_p0;
    logic [WIDTH-1:0]         link_p0;
    logic [WIDTH-1:0]         pc_nxt;
    logic [WIDTH-1:0]         link_nxt;
    logic [WIDTH-1:0]         seq_pc;
    logic signed [WIDTH-1:0]  offset;

    assign op     = op_e'(op_i);
    assign offset = $signed(target_i);
    assign seq_pc = wrap_add(pc_p0, $signed(WIDTH'(STEP)));

`ifdef PC_RAS_EN
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    wptr_p0;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wptr_inc;
    logic [CW-1:0]    count_p0;
    logic             err_p0;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             flush;
    logic             err_set;

    assign full     = (count_p0 == CW'(RAS_DEPTH));
    assign empty    = (count_p0 == '0);
    assign top_idx  = (wptr_p0 == '0) ? PW'(RAS_DEPTH - 1) : wptr_p0 - PW'(1);
    assign wptr_inc = (wptr_p0 == PW'(RAS_DEPTH - 1)) ? '0 : wptr_p0 + PW'(1);
`endif

    always_comb begin
        pc_nxt   = pc_p0;
        link_nxt = link_p0;
`ifdef PC_RAS_EN
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        err_set  = 1'b0;
`endif
        case (op)
            OP_CLEAR: begin
                pc_nxt   = RESET_VECTOR;
                link_nxt = '0;
`ifdef PC_RAS_EN
                flush    = 1'b1;
`endif
            end
            OP_INC:    pc_nxt = seq_pc;
            OP_JUMP: begin
                link_nxt = seq_pc;
                pc_nxt   = target_i;
            end
            OP_BRANCH: pc_nxt = wrap_add(pc_p0, offset);
            OP_CALL: begin
                link_nxt = seq_pc;
                pc_nxt   = target_i;
`ifdef PC_RAS_EN
                push     = 1'b1;
                err_set  = full;
`endif
            end
            OP_RET: begin
`ifdef PC_RAS_EN
                // Underflow falls through to a sequential advance and flags the error.
                if (empty) begin
                    pc_nxt  = seq_pc;
                    err_set = 1'b1;
                end else begin
                    pc_nxt  = ras_mem[top_idx];
                    pop     = 1'b1;
                end
`else
                pc_nxt = link_p0;
`endif
            end
            default: ;
        endcase
    end

    // Stage p0: architectural PC and link registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_p0   <= RESET_VECTOR;
            link_p0 <= '0;
        end else if (en) begin
            pc_p0   <= pc_nxt;
            link_p0 <= link_nxt;
        end
    end

`ifdef PC_RAS_EN
    // Stage p0: stack pointer, occupancy and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_p0  <= '0;
            count_p0 <= '0;
            err_p0   <= 1'b0;
        end else if (en) begin
            if (flush) begin
                wptr_p0  <= '0;
                count_p0 <= '0;
                err_p0   <= 1'b0;
            end else begin
                if (push) begin
                    wptr_p0 <= wptr_inc;
                    if (!full) count_p0 <= count_p0 + CW'(1);
                end else if (pop) begin
                    wptr_p0  <= top_idx;
                    count_p0 <= count_p0 - CW'(1);
                end
                if (err_set) err_p0 <= 1'b1;
            end
        end
    end

    // A push while full lands on the oldest slot, giving the circular overwrite for free.
    always_ff @(posedge clk) begin
        if (reset && en && push) ras_mem[wptr_p0] <= seq_pc;
    end

    assign ras_count_o = count_p0;
    assign ras_full_o  = full;
    assign ras_empty_o = empty;
    assign ras_err_o   = err_p0;
`else
    assign ras_count_o = '0;
    assign ras_full_o  = 1'b0;
    assign ras_empty_o = 1'b1;
    assign ras_err_o   = 1'b0;
`endif

    assign pc_o   = pc_p0;
    assign link_o = link_p0;

endmodule
